turbo_enc_arbiter: RTL and testbench
====================================

# turbo_enc_arbiter

Two-requester round-robin scheduler in front of the turbo encoder control FSM. It grants the single encoder to one of two bit sources at a time and selects that source's block length. It drives the encoder's `data_valid`/`length_flag` inputs, paces the granted source one bit per cycle for exactly one block, and waits out trellis termination before reporting completion. It sits between the input channel buffers and the encoder.

## Interface
Parameters:
- `K_SHORT`, 1056: short block length in bits (`len_sel`=0).
- `K_LONG`, 6144: long block length in bits (`len_sel`=1).
- `TAIL_CYCLES`, 4: encoder termination cycles after the last data bit.
- `CW`, 14: bit-counter width; must hold `K_LONG`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  source has a full block ready.
- `len0`, `len1`  in  1  length select of each source, sampled at grant.
- `gnt0`, `gnt1`  out  1  one-hot grant, held for the whole block including tail.
- `bit_rd`  out  1  granted source must present its next bit this cycle.
- `enc_data_valid`  out  1  to encoder `data_valid`.
- `enc_length_flag`  out  1  to encoder `length_flag`; latched `len` of the granted source.
- `busy`  out  1  high in any state other than IDLE.
- `blk_done`  out  1  one-cycle pulse at the last tail cycle of each block.
- `blk_cnt0`, `blk_cnt1`  out  8  completed blocks per source, wrap 255->0.

## Operation
- States: IDLE, STREAM, TAIL.
- IDLE: if any `req`, grant and go to STREAM.
  - Only one request: grant it.
  - Both requesting: grant the source not served last.
  - `last` pointer resets to 1, so `req0` wins the first tie.
- On grant:
  - Latch `len` into `enc_length_flag`.
  - Load K = `K_LONG` or `K_SHORT`.
  - Clear the bit counter.
  - Update `last`.
- STREAM:
  - `bit_rd` = `enc_data_valid` = 1 every cycle.
  - Counter increments, width `CW`, unsigned.
  - When counter = K-1, go to TAIL, or follow the back-to-back path when configured.
- TAIL:
  - `bit_rd` = `enc_data_valid` = 0; grant held.
  - Counts `TAIL_CYCLES`.
  - On the last tail cycle: pulse `blk_done`, increment the owner's `blk_cnt`, go to IDLE.
  - Grant drops on entry to IDLE.
- `req` and `len` are sampled only at grant. Deasserting `req` mid-block is ignored; the full block is always consumed.
- Reset asserted at any time: state IDLE, all outputs 0, counters 0, `last` = 1, immediately and asynchronously.

## Timing
- Reset values:
  - `gnt0`, `gnt1`, `bit_rd`, `enc_data_valid`, `enc_length_flag`, `busy`, `blk_done` = 0.
  - `blk_cnt0`, `blk_cnt1` = 0.
- All outputs are registered.
- `req` high in IDLE at edge n:
  - `gnt`, `busy`, `bit_rd`, `enc_data_valid` high from cycle n+1.
  - Data cycles are n+1 .. n+K (exactly K `bit_rd` cycles).
  - TAIL cycles are n+K+1 .. n+K+`TAIL_CYCLES`; `blk_done` fires in the last of these.
  - IDLE at n+K+`TAIL_CYCLES`+1. The earliest next grant is one cycle later.
- Minimum per-block occupancy without back-to-back: K+`TAIL_CYCLES`+1 cycles.
- `blk_cnt` wraps from 255 to 0 silently.

## Configuration
- `TURBO_ENC_ARB_B2B_EN`.
- Defined (back-to-back):
  - In the cycle where counter = K-1, if any `req` is high, the arbitration runs on that edge and STREAM restarts for the new owner the next cycle. `enc_data_valid` stays continuously high, using the encoder's overlapped-termination path.
  - A separate countdown of `TAIL_CYCLES` produces `blk_done` and the `blk_cnt` increment for the previous owner.
  - `gnt` switches directly with no idle cycle.
  - If no `req` is pending, behaviour is identical to the undefined case.
- Undefined: every block passes through TAIL and IDLE as above.

## Test plan
- Reset, then `req0`=1 with `len0`=0 -> `gnt0` at cycle 1; exactly 1056 `bit_rd` cycles; `blk_done` at cycle 1060; `blk_cnt0`=1.
- `req0`=`req1`=1 held, `len1`=1 -> grants alternate 0,1,0,1; source-1 blocks show 6144 `bit_rd` cycles with `enc_length_flag`=1.
- `req1` dropped 10 cycles into its block -> block still runs 1056 bits; `gnt1` held until TAIL ends.
- `reset` asserted at bit 500 -> all outputs 0 immediately; after release with `req1`=1 only, `gnt1` next cycle.
- 256 single-source blocks -> `blk_cnt0` wraps to 0; `blk_cnt1` unchanged.
- With `TURBO_ENC_ARB_B2B_EN` and both requesting -> `enc_data_valid` high with no gap across the block boundary; `blk_done` pulses 4 cycles after each block's last bit.

Source files
------------

// File: rtl/turbo_enc_arbiter.sv
// turbo_enc_arbiter
//   Two-source round-robin scheduler in front of the turbo encoder control
//   FSM. Grants the encoder to one source at a time, latches that source's
//   block length, paces one bit per cycle for exactly one block, then waits
//   out trellis termination before reporting completion.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   req0/req1        source has a full block ready (sampled only at grant)
//   len0/len1        per-source length select (0: K_SHORT, 1: K_LONG)
//   gnt0/gnt1        one-hot grant, held through data and tail
//   bit_rd           granted source presents its next bit this cycle
//   enc_data_valid   encoder data_valid
//   enc_length_flag  encoder length_flag (len latched at grant)
//   busy             any state other than IDLE
//   blk_done         one-cycle pulse in the last tail cycle of a block
//   blk_cnt0/1       completed blocks per source, wraps 255->0
//
// Configuration
//   TURBO_ENC_ARB_B2B_EN  back-to-back blocks: a pending request at the last
//                         data bit re-arbitrates immediately and the previous
//                         block's termination is tracked by a side countdown.
module turbo_enc_arbiter #(
  parameter int unsigned K_SHORT     = 1056,
  parameter int unsigned K_LONG      = 6144,
  parameter int unsigned TAIL_CYCLES = 4,
  parameter int unsigned CW          = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       len0,
  input  logic       len1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       bit_rd,
  output logic       enc_data_valid,
  output logic       enc_length_flag,
  output logic       busy,
  output logic       blk_done,
  output logic [7:0] blk_cnt0,
  output logic [7:0] blk_cnt1
);

  localparam int unsigned TW = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES - 1);
  localparam logic [CW-1:0] KS_LAST   = CW'(K_SHORT - 1);
  localparam logic [CW-1:0] KL_LAST   = CW'(K_LONG - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    TAIL   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 0: source 0 owns the encoder
  logic            last_q, last_d;     // source served most recently
  logic            len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tail_q, tail_d;

  logic            gnt0_q, gnt1_q, bit_rd_q, dv_q, busy_q, done_q;
  logic [7:0]      blk_cnt0_q, blk_cnt1_q;

  logic            any_req, pick;
  logic [CW-1:0]   k_last;
  logic            main_done_d, done_d, inc0, inc1;

`ifdef TURBO_ENC_ARB_B2B_EN
  logic            pend_act_q, pend_act_d;
  logic            pend_own_q, pend_own_d;
  logic [TW-1:0]   pend_cnt_q, pend_cnt_d;
  logic            pend_done_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    any_req     = req0 | req1;
    // On a tie, serve the source that was not served last.
    pick        = (req0 & req1) ? ~last_q : req1;
    k_last      = len_q ? KL_LAST : KS_LAST;
`ifdef TURBO_ENC_ARB_B2B_EN
    pend_act_d  = pend_act_q;
    pend_own_d  = pend_own_q;
    pend_cnt_d  = pend_cnt_q;
    if (pend_act_q) begin
      if (pend_cnt_q == TAIL_LAST) pend_act_d = 1'b0;
      else                         pend_cnt_d = pend_cnt_q + TW'(1);
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = STREAM;
          owner_d = pick;
          last_d  = pick;
          len_d   = pick ? len1 : len0;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (cnt_q == k_last) begin
`ifdef TURBO_ENC_ARB_B2B_EN
          if (any_req) begin
            // Re-grant on the last bit; the finishing block's termination
            // is counted by the side countdown while STREAM continues.
            owner_d    = pick;
            last_d     = pick;
            len_d      = pick ? len1 : len0;
            cnt_d      = '0;
            pend_act_d = 1'b1;
            pend_own_d = owner_q;
            pend_cnt_d = '0;
          end else begin
            state_d = TAIL;
            tail_d  = '0;
          end
`else
          state_d = TAIL;
          tail_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TAIL: begin
        if (tail_q == TAIL_LAST) state_d = IDLE;
        else                     tail_d  = tail_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    main_done_d = (state_d == TAIL) && (tail_d == TAIL_LAST);
    inc0        = main_done_d && !owner_q;
    inc1        = main_done_d &&  owner_q;
`ifdef TURBO_ENC_ARB_B2B_EN
    pend_done_d = pend_act_d && (pend_cnt_d == TAIL_LAST);
    inc0        = inc0 | (pend_done_d && !pend_own_d);
    inc1        = inc1 | (pend_done_d &&  pend_own_d);
    done_d      = main_done_d | pend_done_d;
`else
    done_d      = main_done_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      len_q      <= 1'b0;
      cnt_q      <= '0;
      tail_q     <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      bit_rd_q   <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      blk_cnt0_q <= '0;
      blk_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tail_q     <= tail_d;
      gnt0_q     <= (state_d != IDLE) && !owner_d;
      gnt1_q     <= (state_d != IDLE) &&  owner_d;
      bit_rd_q   <= (state_d == STREAM);
      dv_q       <= (state_d == STREAM);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      if (inc0) blk_cnt0_q <= blk_cnt0_q + 8'd1;
      if (inc1) blk_cnt1_q <= blk_cnt1_q + 8'd1;
    end
  end

`ifdef TURBO_ENC_ARB_B2B_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_act_q <= 1'b0;
      pend_own_q <= 1'b0;
      pend_cnt_q <= '0;
    end else begin
      pend_act_q <= pend_act_d;
      pend_own_q <= pend_own_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end
`endif

  assign gnt0            = gnt0_q;
  assign gnt1            = gnt1_q;
  assign bit_rd          = bit_rd_q;
  assign enc_data_valid  = dv_q;
  assign enc_length_flag = len_q;
  assign busy            = busy_q;
  assign blk_done        = done_q;
  assign blk_cnt0        = blk_cnt0_q;
  assign blk_cnt1        = blk_cnt1_q;

endmodule

// File: tb/tb_turbo_enc_arbiter.sv
// tb_turbo_enc_arbiter
//   Directed bench. u_dut uses the default block lengths; u_small uses short
//   blocks so the 256-block counter wrap fits in a short run.
module tb_turbo_enc_arbiter;

`ifdef TURBO_ENC_ARB_B2B_EN
  localparam int SP = 8;    // done-to-done spacing, single source held
`else
  localparam int SP = 13;   // K + TAIL + 1
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, req1, len0, len1;
  logic       gnt0, gnt1, bit_rd, dv, lf, busy, done;
  logic [7:0] cnt0, cnt1;

  logic       s_rst_n, s_req0, s_req1, s_len0, s_len1;
  logic       s_gnt0, s_gnt1, s_bit_rd, s_dv, s_lf, s_busy, s_done;
  logic [7:0] s_cnt0, s_cnt1;

  turbo_enc_arbiter u_dut (
    .clk(clk), .reset(rst_n), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .bit_rd(bit_rd), .enc_data_valid(dv),
    .enc_length_flag(lf), .busy(busy), .blk_done(done),
    .blk_cnt0(cnt0), .blk_cnt1(cnt1)
  );

  turbo_enc_arbiter #(.K_SHORT(8), .K_LONG(16), .TAIL_CYCLES(4), .CW(5)) u_small (
    .clk(clk), .reset(s_rst_n), .req0(s_req0), .req1(s_req1), .len0(s_len0), .len1(s_len1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .bit_rd(s_bit_rd), .enc_data_valid(s_dv),
    .enc_length_flag(s_lf), .busy(s_busy), .blk_done(s_done),
    .blk_cnt0(s_cnt0), .blk_cnt1(s_cnt1)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Follows one block of source src on u_dut. Cycle 1 is the cycle after the
  // first edge following the call. Returns at the first cycle after the grant
  // drops, or when the cycle limit expires.
  task automatic measure(input int src, input bit exp_lf, input int drop_at, input int limit,
                         output int g_cyc, output int nbits, output int done_cyc,
                         output int bad, output int end_cyc);
    int   cyc;
    bit   seen;
    logic g;
    cyc = 0; seen = 0;
    g_cyc = -1; nbits = 0; done_cyc = -1; bad = 0; end_cyc = -1;
    while (cyc < limit) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cyc == drop_at) begin req0 = 1'b0; req1 = 1'b0; end
      g = src ? gnt1 : gnt0;
      if (g) begin
        if (!seen) g_cyc = cyc;
        seen    = 1;
        end_cyc = cyc;
        if (bit_rd) begin
          nbits++;
          if (lf !== exp_lf) bad++;
        end
        if (dv !== bit_rd) bad++;
        if (gnt0 && gnt1) bad++;
        if (done) done_cyc = cyc;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic check_block(input string tag, input int src, input int k, input bit exp_lf,
                             input int drop_at);
    int g, n, d, b, e;
    measure(src, exp_lf, drop_at, k + 20, g, n, d, b, e);
    check_eq({tag, "_gnt_cycle"}, g, 1);
    check_eq({tag, "_bits"},      n, k);
    check_eq({tag, "_done_cycle"}, d, k + 4);
    check_eq({tag, "_gnt_end"},   e, k + 4);
    check_eq({tag, "_flag_bad"},  b, 0);
    if (src == 0) exp_cnt0 = (exp_cnt0 + 1) % 256;
    else          exp_cnt1 = (exp_cnt1 + 1) % 256;
  endtask

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; len0 = 0; len1 = 0;
    s_rst_n = 0; s_req0 = 0; s_req1 = 0; s_len0 = 0; s_len1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {gnt0, gnt1, bit_rd, dv, lf, busy, done}, 0);
    check_eq("rst_cnts", {cnt0, cnt1}, 0);
    rst_n = 1; s_rst_n = 1;

    // Single short block from source 0.
    req0 = 1; len0 = 0;
    check_block("t1", 0, 1056, 1'b0, 1);
    check_eq("t1_cnt0", cnt0, exp_cnt0);
    check_eq("t1_cnt1", cnt1, exp_cnt1);
    check_eq("t1_idle", busy, 0);

`ifndef TURBO_ENC_ARB_B2B_EN
    // Reset mid-cycle, then both sources held: grants alternate 0,1,0,1.
    rst_n = 0;
    #1;
    check_eq("t2_async_cnt0", cnt0, 0);
    exp_cnt0 = 0; exp_cnt1 = 0;
    @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1; len0 = 0; len1 = 1;
    check_block("t2a", 0, 1056, 1'b0, 0);
    check_block("t2b", 1, 6144, 1'b1, 0);
    check_block("t2c", 0, 1056, 1'b0, 0);
    check_block("t2d", 1, 6144, 1'b1, 1);
    check_eq("t2_cnt0", cnt0, exp_cnt0);
    check_eq("t2_cnt1", cnt1, exp_cnt1);
`endif

    // req1 withdrawn 10 cycles into its block.
    req1 = 1; len1 = 0;
    check_block("t3", 1, 1056, 1'b0, 10);
    check_eq("t3_cnt1", cnt1, exp_cnt1);

    // Asynchronous reset at bit 500, then req1 alone.
    req0 = 1; len0 = 0;
    begin
      int nb, guard;
      nb = 0; guard = 0;
      while (nb < 500 && guard < 600) begin
        @(posedge clk); @(negedge clk); guard++;
        if (bit_rd) nb++;
      end
      check_eq("t4_bits_before", nb, 500);
      rst_n = 0;
      #1;
      check_eq("t4_async_outs", {gnt0, gnt1, bit_rd, dv, lf, busy, done}, 0);
      check_eq("t4_async_cnts", {cnt0, cnt1}, 0);
      exp_cnt0 = 0; exp_cnt1 = 0;
      @(posedge clk); @(negedge clk);
      rst_n = 1; req0 = 0; req1 = 1; len1 = 0;
      #1;
      check_eq("t4_no_gnt_yet", gnt1, 0);
      check_block("t4", 1, 1056, 1'b0, 1);
      check_eq("t4_cnt1", cnt1, exp_cnt1);
      check_eq("t4_cnt0", cnt0, 0);
    end

    // 256 short blocks on u_small: blk_cnt0 wraps, blk_cnt1 untouched.
    begin
      int cyc, nd, last_d, sp_bad;
      bit chk;
      cyc = 0; nd = 0; last_d = -1; sp_bad = 0; chk = 0;
      s_req0 = 1; s_len0 = 0;
      while (cyc < 6000) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (chk) begin
          chk = 0;
          if (nd == 255) check_eq("wrap_255", s_cnt0, 255);
          if (nd == 256) begin
            check_eq("wrap_0", s_cnt0, 0);
            break;
          end
        end
        if (s_done) begin
          nd++;
          if (last_d >= 0 && (cyc - last_d) != SP) sp_bad++;
          last_d = cyc;
          if (nd == 255 || nd == 256) chk = 1;
        end
      end
      check_eq("wrap_blocks", nd, 256);
      check_eq("wrap_spacing_bad", sp_bad, 0);
      s_req0 = 0;
      cyc = 0;
      while (s_busy && cyc < 40) begin
        @(posedge clk); @(negedge clk); cyc++;
      end
      check_eq("wrap_drain", s_busy, 0);
      check_eq("wrap_cnt1", s_cnt1, 0);
    end

`ifdef TURBO_ENC_ARB_B2B_EN
    // Both sources held on u_small: no data_valid gap, done 4 cycles after
    // each block's last bit.
    begin
      int   cyc, gaps, bad, nb;
      bit   started;
      logic pg0, pg1;
      int   q[$];
      cyc = 0; gaps = 0; bad = 0; nb = 0; started = 0; pg0 = 0; pg1 = 0;
      s_req0 = 1; s_req1 = 1; s_len0 = 0; s_len1 = 0;
      while (cyc < 100) begin
        @(posedge clk); @(negedge clk); cyc++;
        if (s_busy) started = 1;
        if (started && !s_dv) gaps++;
        if ((pg0 && s_gnt1) || (pg1 && s_gnt0)) begin
          nb++;
          q.push_back(cyc + 3);
        end
        if (s_done) begin
          if (q.size() > 0 && q[0] == cyc) void'(q.pop_front());
          else bad++;
        end
        if (q.size() > 0 && q[0] < cyc) begin
          bad++;
          void'(q.pop_front());
        end
        pg0 = s_gnt0; pg1 = s_gnt1;
      end
      s_req0 = 0; s_req1 = 0;
      check_eq("b2b_dv_gaps", gaps, 0);
      check_eq("b2b_done_bad", bad, 0);
      check_eq("b2b_switches", (nb >= 10) ? 1 : 0, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
